// File: rtl/sort_scheduler.sv
// Front-end job scheduler for the in-place RAM sorter: round-robin intake of per-requester
// sort jobs into a small queue, serial issue over the order interface, per-requester done pulses.
module sort_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_start,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_len,
   output logic [NUM_REQ-1:0]           done_valid,
   output logic                         order_valid,
   input  logic                         order_busy,
   output logic [ADDR_WIDTH-1:0]        order_start,
   output logic [DATA_WIDTH-1:0]        order_len,
   output logic                         sched_idle
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned CntW = IdW + 1;

   typedef logic [IdW-1:0] id_t;
   typedef enum logic [2:0] {StIdle, StIssue, StWait, StRun, StDone} state_e;

   function automatic id_t wrap_inc(input id_t p);
      return (p == id_t'(NUM_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   state_e                  state_q, state_d;
   logic [NUM_REQ-1:0]      pending_q, pending_d;
   id_t                     rr_ptr_q, rr_ptr_d;
   id_t                     cur_id_q, cur_id_d;
   logic                    order_valid_q, order_valid_d;
   logic [ADDR_WIDTH-1:0]   order_start_q, order_start_d;
   logic [DATA_WIDTH-1:0]   order_len_q, order_len_d;

   id_t                     fifo_id_q    [NUM_REQ];
   logic [ADDR_WIDTH-1:0]   fifo_start_q [NUM_REQ];
   logic [DATA_WIDTH-1:0]   fifo_len_q   [NUM_REQ];
   id_t                     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]         count_q;
   logic                    fifo_full, fifo_empty, push, pop;

   logic [NUM_REQ-1:0]      eligible, grant;
   logic                    grant_any;
   id_t                     grant_id;

   assign fifo_full  = (count_q == CntW'(NUM_REQ));
   assign fifo_empty = (count_q == '0);

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [CntW-1:0] sum;
      id_t             idx;
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      eligible  = req_valid & ~pending_q & {NUM_REQ{~fifo_full}};
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         sum = {1'b0, rr_ptr_q} + CntW'(k);
         if (sum >= CntW'(NUM_REQ)) begin
            sum = sum - CntW'(NUM_REQ);
         end
         idx = sum[IdW-1:0];
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
      grant[grant_id] = grant_any;
   end

   assign req_ready = rst ? '0 : grant;
   assign push      = grant_any;
   assign rr_ptr_d  = grant_any ? wrap_inc(grant_id) : rr_ptr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id_q[wr_ptr_q]    <= grant_id;
         fifo_start_q[wr_ptr_q] <= req_start[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
         fifo_len_q[wr_ptr_q]   <= req_len[grant_id*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wrap_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      cur_id_d      = cur_id_q;
      order_valid_d = order_valid_q;
      order_start_d = order_start_q;
      order_len_d   = order_len_q;
      pop           = 1'b0;
      done_valid    = '0;
      if (push) pending_d[grant_id] = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               cur_id_d = fifo_id_q[rd_ptr_q];
               // len >= 2 iff any bit above bit 0 is set; shorter jobs are already sorted
               if (|fifo_len_q[rd_ptr_q][DATA_WIDTH-1:1]) begin
                  order_valid_d = 1'b1;
                  order_start_d = fifo_start_q[rd_ptr_q];
                  order_len_d   = fifo_len_q[rd_ptr_q];
                  state_d       = StIssue;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StIssue: begin
            if (!order_busy) begin
               order_valid_d = 1'b0;
               state_d       = StWait;
            end
         end
         StWait: begin
            if (order_busy) state_d = StRun;
         end
         StRun: begin
            if (!order_busy) state_d = StDone;
         end
         StDone: begin
            done_valid[cur_id_q] = 1'b1;
            pending_d[cur_id_q]  = 1'b0;
            state_d              = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         pending_q     <= '0;
         rr_ptr_q      <= '0;
         cur_id_q      <= '0;
         order_valid_q <= 1'b0;
         order_start_q <= '0;
         order_len_q   <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         rr_ptr_q      <= rr_ptr_d;
         cur_id_q      <= cur_id_d;
         order_valid_q <= order_valid_d;
         order_start_q <= order_start_d;
         order_len_q   <= order_len_d;
      end
   end

   assign order_valid = order_valid_q;
   assign order_start = order_start_q;
   assign order_len   = order_len_q;
   assign sched_idle  = (state_q == StIdle) && fifo_empty;

endmodule

// File: tb/tb_sort_scheduler.sv
// Bench for sort_scheduler: directed scenarios plus randomized traffic against a job-level
// reference model (FIFO of accepted jobs, pending set, round-robin pointer) and a sorter model.
module tb_sort_scheduler;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct {
      int          id;
      logic [15:0] st;
      logic [15:0] ln;
      bit          issued;
   } job_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_start;
   logic [N*DW-1:0]   req_len;
   logic [N-1:0]      done_valid;
   logic              order_valid;
   logic              order_busy;
   logic [AW-1:0]     order_start;
   logic [DW-1:0]     order_len;
   logic              sched_idle;

   sort_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_start   (req_start),
      .req_len     (req_len),
      .done_valid  (done_valid),
      .order_valid (order_valid),
      .order_busy  (order_busy),
      .order_start (order_start),
      .order_len   (order_len),
      .sched_idle  (sched_idle)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model state
   job_t        jq[$];
   logic [N-1:0] pend_m;
   int          rr_m;

   // sorter model state
   int sm, dly_left, run_left, bp_left, run_def;
   bit rnd;

   bit          prev_ov, prev_acc;
   logic [15:0] prev_st, prev_ln;
   logic [N-1:0] prev_done;
   logic [N-1:0] drop_mask, drop_pend;

   int acc_cyc[N];
   int done_cyc[N];
   int ov_cnt;
   int acc_log[$];
   int acc_cyc_log[$];
   int done_log[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_job(input int i, input logic [15:0] st, input logic [15:0] ln);
      req_start[i*AW +: AW] = st;
      req_len[i*DW +: DW]   = ln;
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic tick();
      logic [N-1:0] exp_gnt;
      bit           found, acc_o, exp_idle;
      int           idx;
      job_t         j;
      if (sm == 0) begin
         if (order_valid && bp_left > 0) begin
            order_busy = 1'b1;
            bp_left--;
         end else begin
            order_busy = 1'b0;
         end
      end else if (dly_left > 0) begin
         order_busy = 1'b0;
         dly_left--;
      end else begin
         order_busy = 1'b1;
         run_left--;
         if (run_left <= 0) sm = 0;
      end
      #1;
      exp_gnt = '0;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (rr_m + k) % N;
         if (!found && req_valid[idx] && !pend_m[idx]) begin
            exp_gnt[idx] = 1'b1;
            found        = 1'b1;
         end
      end
      exp_idle = (jq.size() == 0);
      check_eq("req_ready", req_ready, exp_gnt);
      check_eq("sched_idle", sched_idle, exp_idle);
      if (prev_ov && !prev_acc) begin
         check_eq("order_hold_valid", order_valid, 1);
         check_eq("order_hold_start", order_start, prev_st);
         check_eq("order_hold_len", order_len, prev_ln);
      end
      if (prev_acc) check_eq("order_valid_drop", order_valid, 0);
      if (prev_done != 0) check_eq("done_one_cycle", done_valid, 0);
      if (order_valid) ov_cnt++;
      for (int i = 0; i < N; i++) begin
         if (done_valid[i]) begin
            done_cyc[i] = cyc;
            done_log.push_back(i);
         end
      end
      if (done_valid != 0) begin
         if (jq.size() == 0) begin
            check_eq("done_unexpected", done_valid, 0);
         end else begin
            check_eq("done_id", done_valid, 4'b0001 << jq[0].id);
            check_eq("done_after_issue", jq[0].issued, jq[0].ln >= 2);
            pend_m[jq[0].id] = 1'b0;
            void'(jq.pop_front());
         end
      end
      acc_o = order_valid && !order_busy;
      if (acc_o) begin
         if (jq.size() == 0) begin
            check_eq("order_unexpected", order_valid, 0);
         end else begin
            check_eq("order_start", order_start, jq[0].st);
            check_eq("order_len", order_len, jq[0].ln);
            check_eq("order_len_min", order_len >= 2, 1);
            check_eq("order_once", jq[0].issued, 0);
            j        = jq.pop_front();
            j.issued = 1'b1;
            jq.push_front(j);
         end
         sm       = 1;
         dly_left = rnd ? int'($urandom_range(0, 2)) : 0;
         run_left = rnd ? int'($urandom_range(1, 6)) : run_def;
         bp_left  = rnd ? int'($urandom_range(0, 3)) : 0;
      end
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            acc_cyc[i] = cyc;
            acc_log.push_back(i);
            acc_cyc_log.push_back(cyc);
            if (drop_mask[i]) drop_pend[i] = 1'b1;
         end
         if (exp_gnt[i]) begin
            j.id     = i;
            j.st     = req_start[i*AW +: AW];
            j.ln     = req_len[i*DW +: DW];
            j.issued = 1'b0;
            jq.push_back(j);
            pend_m[i] = 1'b1;
            rr_m      = (i + 1) % N;
         end
      end
      prev_ov   = order_valid;
      prev_acc  = acc_o;
      prev_st   = order_start;
      prev_ln   = order_len;
      prev_done = done_valid;
      cyc++;
      @(negedge clk);
      req_valid = req_valid & ~drop_pend;
      drop_pend = '0;
   endtask

   task automatic run_idle();
      int n = 0;
      tick();
      while (n < 400 && !(jq.size() == 0 && sm == 0)) begin
         tick();
         n++;
      end
      if (n >= 400) check_eq("idle_timeout", jq.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst        = 1'b1;
      req_valid  = '0;
      req_start  = '0;
      req_len    = '0;
      order_busy = 1'b0;
      pend_m     = '0;
      rr_m       = 0;
      sm = 0; dly_left = 0; run_left = 0; bp_left = 0; run_def = 3; rnd = 1'b0;
      prev_ov = 1'b0; prev_acc = 1'b0; prev_st = '0; prev_ln = '0; prev_done = '0;
      drop_mask = '1; drop_pend = '0; ov_cnt = 0;
      for (int i = 0; i < N; i++) begin
         acc_cyc[i]  = 0;
         done_cyc[i] = 0;
      end
      repeat (2) @(negedge clk);
      req_valid = '1;
      #1;
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_order_valid", order_valid, 0);
      check_eq("rst_order_start", order_start, 0);
      check_eq("rst_order_len", order_len, 0);
      check_eq("rst_done", done_valid, 0);
      check_eq("rst_idle", sched_idle, 1);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // round-robin from rr_ptr = 0
      for (int i = 0; i < N; i++) set_job(i, 16'h0100 + 16'(i), 16'(4 + i));
      acc_log.delete(); acc_cyc_log.delete(); done_log.delete();
      req_valid = '1;
      run_idle();
      check_eq("rr_grant_count", acc_log.size(), N);
      check_eq("rr_done_count", done_log.size(), N);
      for (int k = 0; k < acc_log.size() && k < N; k++) begin
         check_eq("rr_grant_order", acc_log[k], k);
         check_eq("rr_grant_cycle", acc_cyc_log[k] - acc_cyc_log[0], k);
      end
      for (int k = 0; k < done_log.size() && k < N; k++) check_eq("rr_done_order", done_log[k], k);

      // single job
      set_job(0, 16'h0010, 16'd8);
      ov_cnt = 0;
      req_valid = 4'b0001;
      run_idle();
      check_eq("single_ov_cycles", ov_cnt, 1);
      check_eq("single_done_latency", done_cyc[0] - acc_cyc[0], 7);

      // trivial lengths
      set_job(1, 16'h1111, 16'd0);
      ov_cnt = 0;
      req_valid = 4'b0010;
      run_idle();
      check_eq("trivial0_latency", done_cyc[1] - acc_cyc[1], 2);
      check_eq("trivial0_no_order", ov_cnt, 0);
      set_job(2, 16'h2222, 16'd1);
      ov_cnt = 0;
      req_valid = 4'b0100;
      run_idle();
      check_eq("trivial1_latency", done_cyc[2] - acc_cyc[2], 2);
      check_eq("trivial1_no_order", ov_cnt, 0);

      // sorter back-pressure for 5 cycles during ISSUE
      set_job(3, 16'hBEEF, 16'd5);
      bp_left = 5;
      ov_cnt  = 0;
      req_valid = 4'b1000;
      run_idle();
      check_eq("bp_ov_cycles", ov_cnt, 6);

      // pending block: requester 2 keeps valid high
      drop_mask[2] = 1'b0;
      set_job(2, 16'h2020, 16'd3);
      acc_log.delete(); acc_cyc_log.delete();
      req_valid = 4'b0100;
      n = 0;
      while (n < 100 && acc_log.size() < 2) begin
         tick();
         n++;
      end
      check_eq("pend_second_accept", acc_log.size(), 2);
      if (acc_log.size() >= 2) check_eq("pend_reaccept_gap", acc_cyc_log[1] - done_cyc[2], 1);
      req_valid    = '0;
      drop_mask[2] = 1'b1;
      run_idle();

      // randomized traffic
      rnd = 1'b1;
      drop_mask = '0;
      for (int c = 0; c < 1500; c++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            set_job(i, 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1))
                                                : 16'($urandom_range(2, 300)));
         end
         tick();
      end
      req_valid = '0;
      run_idle();
      rnd = 1'b0;
      bp_left = 0;
      drop_mask = '1;

      // reset while RUN with two jobs queued
      run_def = 20;
      for (int i = 0; i < 3; i++) set_job(i, 16'h0A00 + 16'(i), 16'd10);
      req_valid = 4'b0111;
      n = 0;
      while (n < 80 && !(sm == 1 && run_left <= run_def - 2 && jq.size() == 3)) begin
         tick();
         n++;
      end
      check_eq("rst_reach_run", jq.size(), 3);
      rst = 1'b1;
      req_valid = '1;
      #1;
      check_eq("midrst_req_ready", req_ready, 0);
      check_eq("midrst_order_valid", order_valid, 0);
      check_eq("midrst_order_start", order_start, 0);
      check_eq("midrst_order_len", order_len, 0);
      check_eq("midrst_done", done_valid, 0);
      check_eq("midrst_idle", sched_idle, 1);
      jq.delete();
      pend_m = '0; rr_m = 0; sm = 0; order_busy = 1'b0; run_def = 3;
      prev_ov = 1'b0; prev_acc = 1'b0; prev_done = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("midrst_hold_done", done_valid, 0);
         check_eq("midrst_hold_ov", order_valid, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      tick();
      done_log.delete();
      set_job(3, 16'h3333, 16'd7);
      req_valid = 4'b1000;
      run_idle();
      check_eq("post_rst_done_count", done_log.size(), 1);
      if (done_log.size() >= 1) check_eq("post_rst_done_id", done_log[0], 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sort_scheduler.md
# sort_scheduler

Front-end scheduler for the in-place RAM sorter. Accepts sort jobs from `NUM_REQ` independent requesters and arbitrates them round-robin into a small job queue. Jobs are issued one at a time over the sorter's order interface (`order_valid`/`order_busy`/`order_start`/`order_len`). When the sorter finishes a job, the scheduler returns a one-cycle completion pulse to the owning requester.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `ADDR_WIDTH`, 16: RAM address width; width of job start address
- `DATA_WIDTH`, 16: width of job length field
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a job
- `req_ready`  out  NUM_REQ  one-hot grant; job i accepted on `req_valid[i] && req_ready[i]`
- `req_start`  in  NUM_REQ*ADDR_WIDTH  start address; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_len`  in  NUM_REQ*DATA_WIDTH  element count; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH]
- `done_valid`  out  NUM_REQ  one-cycle pulse; job of requester i completed
- `order_valid`  out  1  job request to sorter (registered)
- `order_busy`  in  1  sorter busy
- `order_start`  out  ADDR_WIDTH  start address to sorter (registered)
- `order_len`  out  DATA_WIDTH  length to sorter (registered)
- `sched_idle`  out  1  high when the queue is empty and the FSM is in IDLE

## Operation
- **Pending mask**: `pending[i]` is set when requester i's job is accepted and cleared in the DONE cycle for that job. Each requester has at most one outstanding job. Consequences:
  - done pulses are unambiguous;
  - the queue (depth `NUM_REQ`) cannot overflow.
- **Arbiter** (combinational grant, registered pointer `rr_ptr`):
  - Requester i is eligible when `req_valid[i] && !pending[i] && !fifo_full`.
  - Grant goes to the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On a grant, `rr_ptr` becomes (granted index + 1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
  - At most one grant per cycle.
- **Job queue**: FIFO of {id, start, len}, depth `NUM_REQ`.
  - Push on grant; pop in IDLE when non-empty.
  - Push and pop in the same cycle are allowed; the count is unchanged.
- **Issue FSM**, states IDLE, ISSUE, WAIT, RUN, DONE:
  - **IDLE**, queue non-empty: pop the head and latch the id.
    - If head len ≥ 2: load `order_start`/`order_len` and set `order_valid`=1, go to ISSUE.
    - If head len < 2 (trivially sorted; the sorter requires ≥ 2): go directly to DONE, with no order issued.
  - **ISSUE**: hold `order_valid`=1 and the data stable until `order_valid && !order_busy`. On that cycle clear `order_valid` and go to WAIT.
  - **WAIT**: on `order_busy`=1 go to RUN. While `order_busy` is 0, stay in WAIT.
  - **RUN**: on `order_busy`=0 go to DONE.
  - **DONE**: drive `done_valid[id]`=1 for one cycle, clear `pending[id]`, go to IDLE.
- **Reset values**:
  - `req_ready` is combinational: 0 while `rst` is asserted, because pending is cleared and the FIFO is empty but grants are gated by reset.
  - 0: `done_valid`, `order_valid`, `order_start`, `order_len`, `pending`, `rr_ptr`, FIFO pointers/count.
  - State: IDLE. `sched_idle`=1 once `rst` deasserts.
- **Reset mid-operation**:
  - All queued and in-flight jobs are discarded with no done pulses.
  - The sorter is reset by the same system reset; the top level inverts `rst` for the sorter's `rst_n`.
- **Width rules**:
  - `len` is compared unsigned against 2.
  - `rr_ptr` and `id` are `$clog2(NUM_REQ)` bits wide.
  - FIFO count is `$clog2(NUM_REQ)+1` bits wide.

## Timing
- Handshake accepted at edge E0 (queue empty, FSM IDLE):
  - edge E1: IDLE pops; `order_valid`=1 becomes visible after E1.
  - edge E2: sorter accepts; the FSM enters WAIT and `order_valid` returns to 0.
  - sorter `order_busy` rises after E2; the FSM enters RUN at E3.
- Completion: the first edge sampling `order_busy`=0 in RUN enters DONE. `done_valid` is high for exactly the following cycle. The next queued job's `order_valid` rises one cycle after that (DONE→IDLE→ISSUE).
- Trivial job, len < 2: `done_valid` is high in the second cycle after the handshake edge (IDLE at E1 → DONE).
- A granted requester may present a new job only after its done pulse. `req_ready[i]` can rise again in the cycle after `done_valid[i]`.
- Issue order is queue order, FIFO across requesters. The arbiter only determines the push order.

## Test plan
- **Single job**: requester 0 submits start=0x0010, len=8. Required: `order_valid` high for exactly one cycle with start=0x0010, len=8; `done_valid[0]` pulses once, after `order_busy` falls; `sched_idle` returns to 1.
- **Round-robin**: all four `req_valid` asserted together, `rr_ptr`=0. Required: grants in order 0,1,2,3 on consecutive cycles; orders issued in that order; done pulses in order 0,1,2,3.
- **Pending block**: requester 2 keeps `req_valid` high after acceptance. Required: `req_ready[2]` stays 0 until the cycle after `done_valid[2]`, and the second job is accepted no earlier than that cycle.
- **Trivial lengths**: len=0 and len=1. Required: no `order_valid` assertion; `done_valid` pulses two cycles after the handshake edge.
- **Sorter back-pressure**: hold `order_busy`=1 from an external model for 5 cycles during ISSUE. Required: `order_valid` stays 1 and `order_start`/`order_len` stay stable until `order_busy`=0.
- **Reset mid-RUN**: assert `rst` while the FSM is in RUN with 2 jobs queued. Required: all outputs return to reset values immediately, with no done pulses; after release, a new job from requester 3 is accepted and completes normally.
